// File: rtl/dct_pkg.sv
// Shared widths, types and helpers for the 4-point DCT-II datapath.
// Inter-stage clip and first-pass shift live here so both passes agree.
package dct_pkg;

   localparam int DCT_IN_W   = 27;
   localparam int DCT_OUT_W  = 19;
   localparam int DCT_CLIP_W = 16;
   localparam int BIT_DEPTH  = 10;
   localparam int SHIFT_FWD1 = 2 + BIT_DEPTH - 9;

   typedef logic [3:0][DCT_IN_W-1:0]  coef_row_t;
   typedef logic [3:0][DCT_OUT_W-1:0] col_t;

   function automatic logic signed [63:0] clip_s(
      input logic signed [63:0] v,
      input int                 cw
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (cw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/rnd_shift_clip.sv
// Round-half-up arithmetic right shift followed by a signed clip.
// Computed one bit wider than the input so the rounding add cannot wrap.
module rnd_shift_clip
   import dct_pkg::*;
#(
   parameter int IN_W   = DCT_IN_W,
   parameter int CLIP_W = DCT_CLIP_W,
   parameter int SHIFT  = SHIFT_FWD1
) (
   input  logic [IN_W-1:0]   y_i,
   output logic [CLIP_W-1:0] t_o
);

   // (1<<SHIFT)>>1 collapses to zero when SHIFT is 0
   localparam logic signed [IN_W:0] RND = (IN_W+1)'((1 << SHIFT) >> 1);

   logic signed [IN_W:0] ext;
   logic signed [IN_W:0] t_w;

   always_comb begin
      ext = signed'({y_i[IN_W-1], y_i});
      t_w = (ext + RND) >>> SHIFT;
      t_o = CLIP_W'(clip_s(64'(t_w), CLIP_W));
   end

endmodule

// File: rtl/dct2_4_tbuf.sv
// Ping-pong 4x4 transpose buffer between row and column DCT passes.
// Rows enter as even/odd halves, columns leave sign-extended.
module dct2_4_tbuf
   import dct_pkg::*;
#(
   parameter int IN_W   = DCT_IN_W,
   parameter int OUT_W  = DCT_OUT_W,
   parameter int CLIP_W = DCT_CLIP_W,
   parameter int SHIFT  = SHIFT_FWD1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0][IN_W-1:0]  in_ye,
   input  logic [1:0][IN_W-1:0]  in_yo,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3:0][OUT_W-1:0] out_col,
   output logic [1:0]            out_idx,
   output logic                  out_last
);

   logic [IN_W-1:0]   row_y [4];
   logic [CLIP_W-1:0] row_t [4];
   logic [CLIP_W-1:0] mem_q [2][4][4];

   logic       wbank_q, wbank_d;
   logic       rbank_q, rbank_d;
   logic [1:0] row_cnt_q, row_cnt_d;
   logic [1:0] col_cnt_q, col_cnt_d;
   logic [1:0] full_q, full_d;
   logic       in_acc;
   logic       out_acc;

   assign row_y[0] = in_ye[0];
   assign row_y[1] = in_yo[0];
   assign row_y[2] = in_ye[1];
   assign row_y[3] = in_yo[1];

   for (genvar k = 0; k < 4; k++) begin : g_rsc
      rnd_shift_clip #(
         .IN_W   (IN_W),
         .CLIP_W (CLIP_W),
         .SHIFT  (SHIFT)
      ) u_rsc (
         .y_i (row_y[k]),
         .t_o (row_t[k])
      );
   end

   // Ready depends only on registered flags, never on out_ready
   assign in_ready  = !full_q[wbank_q];
   assign out_valid = full_q[rbank_q];
   assign in_acc    = in_valid & in_ready;
   assign out_acc   = out_valid & out_ready;

   always_comb begin
      wbank_d   = wbank_q;
      rbank_d   = rbank_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      full_d    = full_q;
      if (in_acc) begin
         row_cnt_d = row_cnt_q + 2'd1;
         if (row_cnt_q == 2'd3) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = !wbank_q;
         end
      end
      if (out_acc) begin
         col_cnt_d = col_cnt_q + 2'd1;
         if (col_cnt_q == 2'd3) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wbank_q   <= 1'b0;
         rbank_q   <= 1'b0;
         row_cnt_q <= 2'd0;
         col_cnt_q <= 2'd0;
         full_q    <= 2'b00;
      end else begin
         wbank_q   <= wbank_d;
         rbank_q   <= rbank_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         full_q    <= full_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_acc) begin
         for (int k = 0; k < 4; k++) begin
            mem_q[wbank_q][row_cnt_q][k] <= row_t[k];
         end
      end
   end

   always_comb begin
      out_col = '0;
      for (int r = 0; r < 4; r++) begin
         if (out_valid) begin
            out_col[r] = {{(OUT_W-CLIP_W){mem_q[rbank_q][r][col_cnt_q][CLIP_W-1]}},
                          mem_q[rbank_q][r][col_cnt_q]};
         end
      end
      out_idx  = col_cnt_q;
      out_last = out_valid && (col_cnt_q == 2'd3);
   end

endmodule

// File: tb/tb_dct2_4_tbuf.sv
// Directed bench for the transpose buffer: SHIFT=3 main instance plus
// a SHIFT=0 instance for the no-rounding path.
module tb_dct2_4_tbuf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             in_valid, in_ready;
   logic [1:0][26:0] in_ye, in_yo;
   logic             out_valid, out_ready;
   logic [3:0][18:0] out_col;
   logic [1:0]       out_idx;
   logic             out_last;

   logic             z_in_valid, z_in_ready;
   logic [1:0][26:0] z_in_ye, z_in_yo;
   logic             z_out_valid, z_out_ready;
   logic [3:0][18:0] z_out_col;
   logic [1:0]       z_out_idx;
   logic             z_out_last;

   int checks = 0;
   int errors = 0;

   dct2_4_tbuf #(.IN_W(27), .OUT_W(19), .CLIP_W(16), .SHIFT(3)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ye     (in_ye),
      .in_yo     (in_yo),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   dct2_4_tbuf #(.IN_W(27), .OUT_W(19), .CLIP_W(16), .SHIFT(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (z_in_valid),
      .in_ready  (z_in_ready),
      .in_ye     (z_in_ye),
      .in_yo     (z_in_yo),
      .out_valid (z_out_valid),
      .out_ready (z_out_ready),
      .out_col   (z_out_col),
      .out_idx   (z_out_idx),
      .out_last  (z_out_last)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input int y0, input int y1, input int y2, input int y3);
      in_ye[0] = 27'(y0);
      in_yo[0] = 27'(y1);
      in_ye[1] = 27'(y2);
      in_yo[1] = 27'(y3);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      z_in_valid = 1'b0;
      z_out_ready = 1'b0;
      set_row(0, 0, 0, 0);
      z_in_ye = '0;
      z_in_yo = '0;
      step;
      step;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
      end
      checks++;
      if (out_idx !== 2'd0 || out_last !== 1'b0) begin
         errors++; $display("FAIL reset_idx_last got %0d/%b exp 0/0", out_idx, out_last);
      end
      checks++;
      if (out_col !== '0) begin
         errors++; $display("FAIL reset_out_col got %h exp 0", out_col);
      end
      checks++;
      if (z_in_ready !== 1'b1 || z_out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_shift0 got rdy %b vld %b exp 1/0", z_in_ready, z_out_valid);
      end
   endtask

   task automatic test_single;
      logic [18:0] ex [4];
      ex[0] = 19'h00003;
      ex[1] = 19'h7FFFE;
      ex[2] = 19'h07FFF;
      ex[3] = 19'h78000;
      out_ready = 1'b1;
      set_row(20, -20, 400000, -400000);
      in_valid = 1'b1;
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_intake row %0d got rdy %b vld %b exp 1/0", r, in_ready, out_valid);
         end
         step;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_last !== (k == 3)) begin
            errors++; $display("FAIL single_ctrl col %0d got vld %b idx %0d last %b", k, out_valid, out_idx, out_last);
         end
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_col[r] !== ex[k]) begin
               errors++; $display("FAIL single_data col %0d row %0d got %h exp %h", k, r, out_col[r], ex[k]);
            end
         end
         step;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL single_done got vld %b exp 0", out_valid);
      end
   endtask

   task automatic test_shift0;
      logic [18:0] ex [4];
      ex[0] = 19'h00005;
      ex[1] = 19'h7FFF9;
      ex[2] = 19'h07FFF;
      ex[3] = 19'h00000;
      z_out_ready = 1'b1;
      z_in_ye[0] = 27'(5);
      z_in_yo[0] = 27'(-7);
      z_in_ye[1] = 27'(40000);
      z_in_yo[1] = 27'(0);
      z_in_valid = 1'b1;
      repeat (4) step;
      z_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (z_out_valid !== 1'b1 || z_out_idx !== 2'(k) || z_out_last !== (k == 3)) begin
            errors++; $display("FAIL shift0_ctrl col %0d got vld %b idx %0d", k, z_out_valid, z_out_idx);
         end
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (z_out_col[r] !== ex[k]) begin
               errors++; $display("FAIL shift0_data col %0d row %0d got %h exp %h", k, r, z_out_col[r], ex[k]);
            end
         end
         step;
      end
   endtask

   task automatic test_back_to_back;
      int seen = 0;
      int b;
      int r;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 12) begin
            b = c / 4;
            r = c % 4;
            set_row(8 * (100 * b + 10 * r), 8 * (100 * b + 10 * r + 1),
                    8 * (100 * b + 10 * r + 2), 8 * (100 * b + 10 * r + 3));
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
               errors++; $display("FAIL stream_in_ready cycle %0d got 0 exp 1", c);
            end
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (seen >= 12) begin
               errors++; $display("FAIL stream_extra column got %0d exp 12", seen + 1);
            end else begin
               if (out_idx !== 2'(seen % 4) || out_last !== (seen % 4 == 3)) begin
                  errors++; $display("FAIL stream_idx got %0d exp %0d", out_idx, seen % 4);
               end
               for (int rr = 0; rr < 4; rr++) begin
                  checks++;
                  if (out_col[rr] !== 19'(100 * (seen / 4) + 10 * rr + seen % 4)) begin
                     errors++; $display("FAIL stream_data col %0d row %0d got %0d exp %0d", seen, rr,
                                        out_col[rr], 100 * (seen / 4) + 10 * rr + seen % 4);
                  end
               end
            end
            seen++;
         end else if (seen > 0 && seen < 12) begin
            checks++;
            errors++; $display("FAIL stream_gap at column %0d got vld 0 exp 1", seen);
         end
         step;
      end
      checks++;
      if (seen != 12) begin
         errors++; $display("FAIL stream_count got %0d exp 12", seen);
      end
   endtask

   task automatic test_backpressure;
      int acc = 0;
      bit have = 1'b0;
      logic [3:0][18:0] snap;
      int v;
      out_ready = 1'b0;
      in_valid = 1'b1;
      snap = '0;
      for (int c = 0; c < 20; c++) begin
         if (in_ready === 1'b1) begin
            v = 100 * (5 + acc / 4) + 10 * (acc % 4);
            set_row(8 * v, 8 * (v + 1), 8 * (v + 2), 8 * (v + 3));
            acc++;
         end
         if (out_valid === 1'b1) begin
            if (!have) begin
               snap = out_col;
               have = 1'b1;
            end else begin
               checks++;
               if (out_col !== snap || out_idx !== 2'd0) begin
                  errors++; $display("FAIL bp_stable cycle %0d got %h exp %h", c, out_col, snap);
               end
            end
         end
         step;
      end
      in_valid = 1'b0;
      checks++;
      if (acc != 8) begin
         errors++; $display("FAIL bp_rows_accepted got %0d exp 8", acc);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_full got rdy %b vld %b exp 0/1", in_ready, out_valid);
      end
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         checks++;
         if (in_ready !== (j >= 4)) begin
            errors++; $display("FAIL bp_in_ready col %0d got %b exp %b", j, in_ready, j >= 4);
         end
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(j % 4)) begin
            errors++; $display("FAIL bp_drain_ctrl col %0d got vld %b idx %0d", j, out_valid, out_idx);
         end
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_col[r] !== 19'(100 * (5 + j / 4) + 10 * r + j % 4)) begin
               errors++; $display("FAIL bp_drain_data col %0d row %0d got %0d exp %0d", j, r,
                                  out_col[r], 100 * (5 + j / 4) + 10 * r + j % 4);
            end
         end
         step;
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_done got vld %b exp 0", out_valid);
      end
   endtask

   task automatic test_transpose;
      int base [4];
      base[0] = 0;
      base[1] = 13;
      base[2] = 25;
      base[3] = 38;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int r = 0; r < 4; r++) begin
         set_row(100 * r, 100 * r + 8, 100 * r + 16, 100 * r + 24);
         step;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_valid !== 1'b1 || out_col[r] !== 19'(base[r] + k)) begin
               errors++; $display("FAIL transpose col %0d row %0d got %0d exp %0d", k, r, out_col[r], base[r] + k);
            end
         end
         step;
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      in_valid = 1'b1;
      set_row(8 * 777, 8 * 777, 8 * 777, 8 * 777);
      repeat (2) step;
      in_valid = 1'b0;
      rst = 1'b1;
      step;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_partial got vld %b rdy %b exp 0/1", out_valid, in_ready);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_partial_idle cycle %0d got vld 1 exp 0", i);
         end
         step;
      end
      in_valid = 1'b1;
      for (int r = 0; r < 4; r++) begin
         set_row(8 * (300 + 10 * r), 8 * (301 + 10 * r), 8 * (302 + 10 * r), 8 * (303 + 10 * r));
         step;
      end
      in_valid = 1'b0;
      repeat (2) step;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd2) begin
         errors++; $display("FAIL rst_predrain got vld %b idx %0d exp 1/2", out_valid, out_idx);
      end
      rst = 1'b1;
      step;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 2'd0 || out_last !== 1'b0) begin
         errors++; $display("FAIL rst_middrain got vld %b rdy %b idx %0d exp 0/1/0", out_valid, in_ready, out_idx);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_drain_idle cycle %0d got vld 1 exp 0", i);
         end
         step;
      end
      in_valid = 1'b1;
      for (int r = 0; r < 4; r++) begin
         set_row(8 * (400 + 10 * r), 8 * (401 + 10 * r), 8 * (402 + 10 * r), 8 * (403 + 10 * r));
         step;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(k)) begin
            errors++; $display("FAIL rst_recover_ctrl col %0d got vld %b idx %0d", k, out_valid, out_idx);
         end
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_col[r] !== 19'(400 + 10 * r + k)) begin
               errors++; $display("FAIL rst_recover_data col %0d row %0d got %0d exp %0d", k, r,
                                  out_col[r], 400 + 10 * r + k);
            end
         end
         step;
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_shift0;
      test_back_to_back;
      test_backpressure;
      test_transpose;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
